// File: rtl/comperator_row_scheduler_if.sv
// Control/status bundle between the register front end (master) and the
// comparator row scheduler (slave), including the per-engine go/done lines.
interface comperator_row_scheduler_if #(
  parameter int NUM_ENGINES = 2,
  parameter int ROW_W       = 10
);
  logic                         start;
  logic                         abort;
  logic [ROW_W-1:0]             num_rows;
  logic [NUM_ENGINES-1:0]       go;
  logic [NUM_ENGINES*ROW_W-1:0] row_idx;
  logic [NUM_ENGINES-1:0]       done;
  logic                         busy;
  logic                         frame_done;
  logic [ROW_W:0]               rows_completed;

  modport master (
    output start, abort, num_rows, done,
    input  go, row_idx, busy, frame_done, rows_completed
  );

  modport slave (
    input  start, abort, num_rows, done,
    output go, row_idx, busy, frame_done, rows_completed
  );
endinterface

// File: rtl/comperator_row_scheduler.sv
// Hands frame rows, one per go pulse, to NUM_ENGINES comparator engines.
// Define ROW_SCHED_ROUND_ROBIN_EN for round-robin engine selection; default is lowest-index priority.
module comperator_row_scheduler #(
  parameter int NUM_ENGINES = 2,
  parameter int ROW_W       = 10
) (
  input logic                       aclk,
  input logic                       aresetn,
  comperator_row_scheduler_if.slave sched
);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_FINISH} state_e;

  state_e                       state_q, state_d;
  logic [ROW_W-1:0]             num_rows_q, num_rows_d;
  logic [ROW_W-1:0]             next_row_q, next_row_d;
  logic [NUM_ENGINES-1:0]       eng_busy_q, eng_busy_d;
  logic [NUM_ENGINES-1:0]       go_q, go_d;
  logic [NUM_ENGINES*ROW_W-1:0] row_idx_q, row_idx_d;
  logic                         busy_q, busy_d;
  logic                         frame_done_q, frame_done_d;
  logic [ROW_W:0]               rows_completed_q, rows_completed_d;

  logic [NUM_ENGINES-1:0]       accepted;
  logic [NUM_ENGINES-1:0]       grant;
  logic [ROW_W:0]               accepted_cnt;
  logic                         dispatch;

  // A done only counts for an engine that actually holds a row.
  assign accepted = sched.done & eng_busy_q;

  always_comb begin
    accepted_cnt = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      accepted_cnt = accepted_cnt + (ROW_W+1)'(accepted[i]);
    end
  end

  assign dispatch = (state_q == S_DISPATCH) && (next_row_q < num_rows_q) &&
                    (|grant) && !sched.abort;

`ifdef ROW_SCHED_ROUND_ROBIN_EN
  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  logic [IDX_W-1:0] rr_last_q, rr_last_d;

  // Descending distance so the free engine closest after rr_last_q is written last.
  always_comb begin
    grant = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (i == (int'(rr_last_q) + 1 + k) % NUM_ENGINES && !eng_busy_q[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_last_d = rr_last_q;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (dispatch && grant[i]) rr_last_d = IDX_W'(i);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) rr_last_q <= IDX_W'(NUM_ENGINES - 1);
    else          rr_last_q <= rr_last_d;
  end
`else
  always_comb begin
    grant = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (!eng_busy_q[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`endif

  // NOTE: every signal gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d          = state_q;
    num_rows_d       = num_rows_q;
    next_row_d       = next_row_q;
    eng_busy_d       = eng_busy_q & ~accepted;
    go_d             = '0;
    row_idx_d        = row_idx_q;
    rows_completed_d = rows_completed_q + accepted_cnt;

    if (dispatch) begin
      go_d       = grant;
      eng_busy_d = eng_busy_d | grant;
      next_row_d = next_row_q + ROW_W'(1);
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (grant[i]) row_idx_d[i*ROW_W +: ROW_W] = next_row_q;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (sched.start) begin
          num_rows_d       = sched.num_rows;
          next_row_d       = '0;
          rows_completed_d = '0;
          state_d          = (sched.num_rows == '0) ? S_FINISH : S_DISPATCH;
        end
      end
      S_DISPATCH: if (dispatch && next_row_d == num_rows_q) state_d = S_DRAIN;
      S_DRAIN:    if (eng_busy_q == '0) state_d = S_FINISH;
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Abort drops outstanding work but leaves row_idx/rows_completed visible.
    if (sched.abort) begin
      state_d          = S_IDLE;
      eng_busy_d       = '0;
      rows_completed_d = rows_completed_q;
    end

    busy_d       = (state_d == S_DISPATCH) || (state_d == S_DRAIN);
    frame_done_d = (state_d == S_FINISH);
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q          <= S_IDLE;
      num_rows_q       <= '0;
      next_row_q       <= '0;
      eng_busy_q       <= '0;
      go_q             <= '0;
      row_idx_q        <= '0;
      busy_q           <= 1'b0;
      frame_done_q     <= 1'b0;
      rows_completed_q <= '0;
    end else begin
      state_q          <= state_d;
      num_rows_q       <= num_rows_d;
      next_row_q       <= next_row_d;
      eng_busy_q       <= eng_busy_d;
      go_q             <= go_d;
      row_idx_q        <= row_idx_d;
      busy_q           <= busy_d;
      frame_done_q     <= frame_done_d;
      rows_completed_q <= rows_completed_d;
    end
  end

  assign sched.go             = go_q;
  assign sched.row_idx        = row_idx_q;
  assign sched.busy           = busy_q;
  assign sched.frame_done     = frame_done_q;
  assign sched.rows_completed = rows_completed_q;

endmodule
